// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the iterative radix-2 Booth multiplier.
//   booth_state_t    : controller states IDLE / RUN / DONE
//   BOOTH_NOP/ADD/SUB: step encodings of the {Q[0], q_1} Booth pair
//   booth_cnt_width(): bit width of the step counter for a given operand width
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // The counter must hold WIDTH+1 (one step per extended operand bit).
  function automatic int unsigned booth_cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_seq_mul_if.sv
// booth_seq_mul_if: operand and result handshakes of booth_seq_mul.
//   in_valid/in_ready/a/b/is_signed : operand side
//   out_valid/out_ready/product     : result side
//   ovf                             : overflow flag, only with BOOTH_OVF_FLAG_EN
// Modports: master = producer/consumer around the multiplier, slave = multiplier.
interface booth_seq_mul_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
`ifdef BOOTH_OVF_FLAG_EN
  logic                 ovf;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product, ovf
  );
  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product, ovf
  );
`else
  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product
  );
  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product
  );
`endif
endinterface

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth step on W1-bit registers.
//   i_a, i_q, i_q_1 : current accumulator, multiplier and appended bit
//   i_m             : multiplicand
//   o_a, o_q, o_q_1 : values after add/sub and the arithmetic right shift
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned W1 = 17
) (
  input  logic [W1-1:0] i_a,
  input  logic [W1-1:0] i_q,
  input  logic          i_q_1,
  input  logic [W1-1:0] i_m,
  output logic [W1-1:0] o_a,
  output logic [W1-1:0] o_q,
  output logic          o_q_1
);

  logic [W1-1:0] w_sum;

  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q_1})
      BOOTH_ADD: w_sum = i_a + i_m;
      BOOTH_SUB: w_sum = i_a - i_m;
      default:   w_sum = i_a;  // BOOTH_NOP and 2'b11
    endcase
  end

  // Arithmetic shift of {A,Q,q_1}: sign of A replicated, A[0] enters Q.
  assign o_a   = {w_sum[W1-1], w_sum[W1-1:1]};
  assign o_q   = {w_sum[0], i_q[W1-1:1]};
  assign o_q_1 = i_q[0];

endmodule

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: iterative radix-2 Booth multiplier, one step per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : booth_seq_mul_if.slave (operand handshake, result handshake)
// Operands are extended to WIDTH+1 bits (sign or zero by is_signed) so both
// modes share one signed datapath; the product is valid WIDTH+1 cycles
// after acceptance and held until taken.
// Optional feature macro: BOOTH_OVF_FLAG_EN adds the registered ovf flag.
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  booth_seq_mul_if.slave bus
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned CW = booth_cnt_width(WIDTH);

  booth_state_t       r_state;
  logic [W1-1:0]      r_a;
  logic [W1-1:0]      r_q;
  logic [W1-1:0]      r_m;
  logic               r_q_1;
  logic [CW-1:0]      r_count;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_product;

  logic [W1-1:0]      w_a_nxt;
  logic [W1-1:0]      w_q_nxt;
  logic               w_q_1_nxt;
  logic [2*WIDTH-1:0] w_product;

  booth_step #(.W1(W1)) u_step (
    .i_a   (r_a),
    .i_q   (r_q),
    .i_q_1 (r_q_1),
    .i_m   (r_m),
    .o_a   (w_a_nxt),
    .o_q   (w_q_nxt),
    .o_q_1 (w_q_1_nxt)
  );

  // Low 2*WIDTH bits of {A,Q} after the final step.
  assign w_product = {w_a_nxt[WIDTH-2:0], w_q_nxt};

`ifdef BOOTH_OVF_FLAG_EN
  logic r_signed;
  logic r_ovf;
  logic w_ovf;

  // Signed: upper WIDTH+1 bits must be pure sign copies.
  // Unsigned: upper WIDTH bits must be zero.
  assign w_ovf = r_signed
               ? !((&w_product[2*WIDTH-1:WIDTH-1]) || !(|w_product[2*WIDTH-1:WIDTH-1]))
               : (|w_product[2*WIDTH-1:WIDTH]);
  assign bus.ovf = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_q_1       <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_product   <= '0;
`ifdef BOOTH_OVF_FLAG_EN
      r_signed    <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // in_ready is exactly (state == IDLE), so in_valid here is a handshake.
          if (bus.in_valid) begin
            r_a     <= '0;
            r_q     <= {bus.is_signed & bus.b[WIDTH-1], bus.b};
            r_m     <= {bus.is_signed & bus.a[WIDTH-1], bus.a};
            r_q_1   <= 1'b0;
            r_count <= CW'(W1);
            r_state <= RUN;
`ifdef BOOTH_OVF_FLAG_EN
            r_signed <= bus.is_signed;
`endif
          end
        end
        RUN: begin
          r_a     <= w_a_nxt;
          r_q     <= w_q_nxt;
          r_q_1   <= w_q_1_nxt;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_product   <= w_product;
`ifdef BOOTH_OVF_FLAG_EN
            r_ovf       <= w_ovf;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.product   = r_product;

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: self-checking bench for booth_seq_mul at WIDTH=16 and
// WIDTH=5, with a behavioural integer-multiplication reference model.
// Build with BOOTH_OVF_FLAG_EN defined to also check the ovf flag.
module tb_booth_seq_mul;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic cap_ovf16 = 1'b0;
  logic cap_ovf5 = 1'b0;

  always #5 clk = ~clk;

  booth_seq_mul_if #(.WIDTH(16)) bus16 ();
  booth_seq_mul_if #(.WIDTH(5))  bus5 ();

  booth_seq_mul #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  booth_seq_mul #(.WIDTH(5))  u_dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer product of the operands interpreted by mode.
  function automatic longint op_val(input int w, input logic [15:0] v, input bit s);
    longint r;
    r = longint'(v);
    if (s && v[w-1]) r -= longint'(1) << w;
    return r;
  endfunction

  function automatic logic [63:0] ref_prod(input int w, input logic [15:0] a, input logic [15:0] b, input bit s);
    longint p;
    p = op_val(w, a, s) * op_val(w, b, s);
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic ref_ovf(input int w, input logic [15:0] a, input logic [15:0] b, input bit s);
    longint p;
    p = op_val(w, a, s) * op_val(w, b, s);
    if (s) return (p < -(longint'(1) << (w - 1))) || (p >= (longint'(1) << (w - 1)));
    return p >= (longint'(1) << w);
  endfunction

  function automatic logic [15:0] rand_op(input int w);
    logic [15:0] m;
    m = 16'((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return m;
      2:       return 16'(32'd1 << (w - 1));
      3:       return m >> 1;
      default: return 16'($urandom) & m;
    endcase
  endfunction

  // ---------------- WIDTH=16 lane ----------------
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input bit s);
    int guard = 0;
    bus16.a = a; bus16.b = b; bus16.is_signed = s; bus16.in_valid = 1'b1;
    while (!bus16.in_ready && guard < 200) begin tick(); guard++; end
    check_val("accept16", 64'(bus16.in_ready), 64'd1);
    tick();
    bus16.in_valid = 1'b0;
  endtask

  task automatic recv16(input bit rnd, output logic [31:0] p, output int lat);
    int guard = 0;
    lat = 0;
    while (!bus16.out_valid && lat < 200) begin
      if (rnd) bus16.out_ready = 1'($urandom_range(0, 1));
      tick(); lat++;
    end
    check_val("valid16", 64'(bus16.out_valid), 64'd1);
    p = bus16.product;
`ifdef BOOTH_OVF_FLAG_EN
    cap_ovf16 = bus16.ovf;
`endif
    while (!bus16.out_ready && guard < 200) begin
      tick(); guard++;
      check_val("hold16", 64'(bus16.product), 64'(p));
      if (rnd) bus16.out_ready = 1'($urandom_range(0, 1));
    end
    tick();
    check_val("drop16", 64'(bus16.out_valid), 64'd0);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input bit s, input logic [31:0] exp);
    logic [31:0] p;
    int lat;
    send16(a, b, s);
    recv16(1'b0, p, lat);
    check_val({tag, "_prod"}, 64'(p), 64'(exp));
    check_val({tag, "_lat"}, 64'(lat), 64'd17);
`ifdef BOOTH_OVF_FLAG_EN
    check_val({tag, "_ovf"}, 64'(cap_ovf16), 64'(ref_ovf(16, a, b, s)));
`endif
  endtask

  task automatic sweep16(input int n);
    logic [15:0] a, b;
    logic [31:0] p;
    bit s;
    int lat;
    for (int i = 0; i < n; i++) begin
      a = rand_op(16); b = rand_op(16); s = 1'($urandom_range(0, 1));
      send16(a, b, s);
      recv16(1'b1, p, lat);
      check_val("sweep16_prod", 64'(p), ref_prod(16, a, b, s));
      check_val("sweep16_lat", 64'(lat), 64'd17);
`ifdef BOOTH_OVF_FLAG_EN
      check_val("sweep16_ovf", 64'(cap_ovf16), 64'(ref_ovf(16, a, b, s)));
`endif
    end
    bus16.out_ready = 1'b1;
  endtask

  // ---------------- WIDTH=5 lane ----------------
  task automatic sweep5(input int n);
    logic [15:0] a, b;
    logic [9:0] p;
    bit s;
    int lat, guard;
    for (int i = 0; i < n; i++) begin
      a = rand_op(5); b = rand_op(5); s = 1'($urandom_range(0, 1));
      bus5.a = a[4:0]; bus5.b = b[4:0]; bus5.is_signed = s; bus5.in_valid = 1'b1;
      guard = 0;
      while (!bus5.in_ready && guard < 200) begin tick(); guard++; end
      check_val("accept5", 64'(bus5.in_ready), 64'd1);
      tick();
      bus5.in_valid = 1'b0;
      lat = 0;
      while (!bus5.out_valid && lat < 200) begin
        bus5.out_ready = 1'($urandom_range(0, 1));
        tick(); lat++;
      end
      check_val("sweep5_lat", 64'(lat), 64'd6);
      p = bus5.product;
`ifdef BOOTH_OVF_FLAG_EN
      cap_ovf5 = bus5.ovf;
      check_val("sweep5_ovf", 64'(cap_ovf5), 64'(ref_ovf(5, a, b, s)));
`endif
      check_val("sweep5_prod", 64'(p), ref_prod(5, a, b, s));
      guard = 0;
      while (!bus5.out_ready && guard < 200) begin
        tick(); guard++;
        check_val("hold5", 64'(bus5.product), 64'(p));
        bus5.out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      check_val("drop5", 64'(bus5.out_valid), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p;
    int n;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.is_signed = 1'b0; bus16.out_ready = 1'b0;
    bus5.in_valid = 1'b0;  bus5.a = '0;  bus5.b = '0;  bus5.is_signed = 1'b0;  bus5.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_val("rst_in_ready16", 64'(bus16.in_ready), 64'd1);
    check_val("rst_out_valid16", 64'(bus16.out_valid), 64'd0);
    check_val("rst_product16", 64'(bus16.product), 64'd0);
    check_val("rst_in_ready5", 64'(bus5.in_ready), 64'd1);
    check_val("rst_out_valid5", 64'(bus5.out_valid), 64'd0);
`ifdef BOOTH_OVF_FLAG_EN
    check_val("rst_ovf16", 64'(bus16.ovf), 64'd0);
`endif
    rst_n = 1'b1;
    bus16.out_ready = 1'b1;

    run16("s3xm5",   16'h0003, 16'hFFFB, 1'b1, 32'hFFFF_FFF1);
    run16("smin2",   16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    run16("umax2",   16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    run16("uff_100", 16'h00FF, 16'h0100, 1'b0, 32'h0000_FF00);
    run16("s7x3",    16'h0007, 16'h0003, 1'b1, 32'h0000_0015);

    // Stall in DONE with out_ready low; in_valid pulses must be ignored.
    bus16.out_ready = 1'b0;
    send16(16'h1234, 16'h5678, 1'b0);
    n = 0;
    while (!bus16.out_valid && n < 200) begin tick(); n++; end
    check_val("stall_valid", 64'(bus16.out_valid), 64'd1);
    p = bus16.product;
    check_val("stall_prod", 64'(p), ref_prod(16, 16'h1234, 16'h5678, 1'b0));
    for (int i = 0; i < 10; i++) begin
      bus16.in_valid = 1'(i % 2 == 0);
      bus16.a = 16'($urandom); bus16.b = 16'($urandom);
      tick();
      check_val("stall_hold", 64'(bus16.product), 64'(p));
      check_val("stall_in_ready", 64'(bus16.in_ready), 64'd0);
      check_val("stall_out_valid", 64'(bus16.out_valid), 64'd1);
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    tick();
    check_val("stall_xfer", 64'(bus16.out_valid), 64'd0);
    check_val("stall_idle", 64'(bus16.in_ready), 64'd1);
    n = 0;
    repeat (20) begin
      tick();
      if (bus16.out_valid || !bus16.in_ready) n++;
    end
    check_val("stall_no_queue", 64'(n), 64'd0);

    // Reset sampled at the end of the 8th RUN cycle aborts the transaction.
    send16(16'h0055, 16'h00AA, 1'b1);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    check_val("abort_in_ready", 64'(bus16.in_ready), 64'd1);
    check_val("abort_out_valid", 64'(bus16.out_valid), 64'd0);
    check_val("abort_product", 64'(bus16.product), 64'd0);
    rst_n = 1'b1;
    run16("s100xm2", 16'd100, 16'hFFFE, 1'b1, 32'hFFFF_FF38);

    fork
      sweep16(40);
      sweep5(60);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
